// File: rtl/lmc_sequencer.sv
// Fetch/decode/execute sequencer for the LMC datapath: owns PC and IR and drives every RAM/accumulator strobe.
// Optional single-step pushbutton input enabled by defining LMC_STEP_EN.
module lmc_sequencer #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  timer555,
    input  logic                  reset_count,
    input  logic                  run,
`ifdef LMC_STEP_EN
    input  logic                  step,
`endif
    input  logic [DATA_WIDTH-1:0] ram_data,
    input  logic                  acc_zero,
    input  logic                  acc_neg,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] ir,
    output logic                  ram_we,
    output logic                  acc_load,
    output logic [1:0]            alu_op,
    output logic [1:0]            state_out,
    output logic                  halted
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_STA = 3'b011;
    localparam logic [2:0] OP_LDA = 3'b100;
    localparam logic [2:0] OP_BRA = 3'b101;
    localparam logic [2:0] OP_BRZ = 3'b110;
    localparam logic [2:0] OP_BRP = 3'b111;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   pc_q;
    logic [DATA_WIDTH-1:0]   ir_q;
    logic                    halted_q;
    logic [2:0]              opcode;
    logic [ADDR_WIDTH-1:0]   operand;
    logic                    branch_d;
    logic                    step_go;

    assign opcode  = ir_q[DATA_WIDTH-1 -: 3];
    assign operand = ir_q[ADDR_WIDTH-1:0];

`ifdef LMC_STEP_EN
    logic step_meta_q, step_sync_q, step_prev_q;

    always_ff @(posedge timer555 or posedge reset_count) begin
        if (reset_count) begin
            step_meta_q <= 1'b0;
            step_sync_q <= 1'b0;
            step_prev_q <= 1'b0;
        end else begin
            step_meta_q <= step;
            step_sync_q <= step_meta_q;
            step_prev_q <= step_sync_q;
        end
    end

    // Only consumed in IDLE, so edges seen mid-instruction simply vanish.
    assign step_go = step_sync_q & ~step_prev_q;
`else
    assign step_go = 1'b0;
`endif

    always_comb begin
        branch_d = 1'b0;
        case (opcode)
            OP_BRA:  branch_d = 1'b1;
            OP_BRZ:  branch_d = acc_zero;
            OP_BRP:  branch_d = ~acc_neg;
            default: branch_d = 1'b0;
        endcase
    end

    always_ff @(posedge timer555 or posedge reset_count) begin
        if (reset_count) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (run || step_go) state_q <= S_FETCH;
                end
                S_FETCH: begin
                    ir_q    <= ram_data;
                    pc_q    <= pc_q + ADDR_WIDTH'(1);
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    if (opcode == OP_HLT) begin
                        halted_q <= 1'b1;
                        state_q  <= S_HALT;
                    end else begin
                        state_q  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (branch_d) pc_q <= operand;
                    state_q <= run ? S_FETCH : S_IDLE;
                end
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Strobes decode the registered state, so an async reset drops them at once.
    always_comb begin
        addr_out = operand;
        ram_we   = 1'b0;
        acc_load = 1'b0;
        alu_op   = 2'b00;
        if (state_q == S_IDLE || state_q == S_FETCH) addr_out = pc_q;
        if (state_q == S_EXEC) begin
            case (opcode)
                OP_LDA: acc_load = 1'b1;
                OP_ADD: begin acc_load = 1'b1; alu_op = 2'b01; end
                OP_SUB: begin acc_load = 1'b1; alu_op = 2'b10; end
                OP_STA: ram_we = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        case (state_q)
            S_IDLE:   state_out = 2'b00;
            S_FETCH:  state_out = 2'b01;
            S_DECODE: state_out = 2'b10;
            S_EXEC:   state_out = 2'b11;
            S_HALT:   state_out = 2'b10;
            default:  state_out = 2'b00;
        endcase
    end

    assign pc     = pc_q;
    assign ir     = ir_q;
    assign halted = halted_q;

endmodule
